// File: rtl/alu_writeback_stage_pkg.sv
// Shared encodings for the ALU write-back stage: source select, FSM states,
// flag bit positions and the link-address helper.
package alu_writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_src_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_WRITE    = 2'b10
    } wb_state_e;

    // FLAGS is packed {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [15:0] link_addr(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_wb_src_mux.sv
// Combinational 4:1 selection of the register-file write data.
module alu_writeback_stage_wb_src_mux
    import alu_writeback_stage_pkg::*;
(
    input  wb_src_e     i_src,
    input  logic [15:0] i_alu,
    input  logic [15:0] i_mem,
    input  logic [15:0] i_link,
    input  logic [15:0] i_imm,
    output logic [15:0] o_data
);

    // Source select
    always_comb begin
        o_data = 16'h0000;
        case (i_src)
            WB_ALU:  o_data = i_alu;
            WB_MEM:  o_data = i_mem;
            WB_LINK: o_data = i_link;
            WB_IMM:  o_data = i_imm;
            default: o_data = 16'h0000;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Write-back stage: captures ALU result/flags, waits for load data with a
// bounded timeout, and issues a single-cycle register-file write.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_issue,
    output logic        wb_ready,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_Z,
    input  logic        ALU_N,
    input  logic        ALU_C,
    input  logic        ALU_V,
    input  logic [15:0] PC,
    input  logic [15:0] D_Imm,
    input  logic [3:0]  D_WriteReg,
    input  logic [1:0]  C_WBSrc,
    input  logic        C_RegWrite,
    input  logic        C_FlagWrite,
    input  logic        C_MemRead,
    output logic        mem_req,
    input  logic        mem_valid,
    input  logic [15:0] D_MemData,
    output logic        RF_WE,
    output logic [3:0]  RF_WADDR,
    output logic [15:0] RF_WDATA,
    output logic [3:0]  FLAGS,
    output logic [15:0] ALUOut_Reg,
    output logic        wb_done,
    output logic        wb_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    wb_state_e   r_state;
    logic [7:0]  r_cnt;
    logic        r_ready;
    logic        r_req;
    logic        r_we;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_alu;
    logic [15:0] r_mem;
    logic [15:0] r_link;
    logic [15:0] r_imm;
    logic [3:0]  r_waddr;
    wb_src_e     r_src;
    logic        r_regwrite;
    logic [3:0]  r_flags;

    wb_state_e   w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_ready_nxt;
    logic        w_req_nxt;
    logic        w_we_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_capture;
    logic        w_mem_capture;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = 1'b0;
        w_req_nxt     = 1'b0;
        w_we_nxt      = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_capture     = 1'b0;
        w_mem_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb_issue) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = 8'd0;
                    if (C_MemRead) begin
                        w_state_nxt = ST_MEM_WAIT;
                        w_req_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_we_nxt    = C_RegWrite && (D_WriteReg != 4'd0);
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Data arriving on the final allowed cycle still completes the load
                if (mem_valid) begin
                    w_mem_capture = 1'b1;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = ST_WRITE;
                    w_we_nxt      = r_regwrite && (r_waddr != 4'd0);
                    w_done_nxt    = 1'b1;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    w_req_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, timeout counter and registered handshake/pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Instruction payload capture; load data slot cleared on issue so a
    // memory-sourced write without a load yields zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu      <= 16'h0000;
            r_mem      <= 16'h0000;
            r_link     <= 16'h0000;
            r_imm      <= 16'h0000;
            r_waddr    <= 4'd0;
            r_src      <= WB_ALU;
            r_regwrite <= 1'b0;
            r_flags    <= 4'b0000;
        end else begin
            if (w_capture) begin
                r_alu      <= ALU_OUT;
                r_mem      <= 16'h0000;
                r_link     <= link_addr(PC);
                r_imm      <= D_Imm;
                r_waddr    <= D_WriteReg;
                r_src      <= wb_src_e'(C_WBSrc);
                r_regwrite <= C_RegWrite;
                if (C_FlagWrite) begin
                    r_flags[FLAG_Z] <= ALU_Z;
                    r_flags[FLAG_N] <= ALU_N;
                    r_flags[FLAG_C] <= ALU_C;
                    r_flags[FLAG_V] <= ALU_V;
                end
            end
            if (w_mem_capture) begin
                r_mem <= D_MemData;
            end
        end
    end

    alu_writeback_stage_wb_src_mux u_wb_src_mux (
        .i_src  (r_src),
        .i_alu  (r_alu),
        .i_mem  (r_mem),
        .i_link (r_link),
        .i_imm  (r_imm),
        .o_data (RF_WDATA)
    );

    assign wb_ready   = r_ready;
    assign mem_req    = r_req;
    assign RF_WE      = r_we;
    assign wb_done    = r_done;
    assign wb_err     = r_err;
    assign RF_WADDR   = r_waddr;
    assign FLAGS      = r_flags;
    assign ALUOut_Reg = r_alu;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: default-timeout instance plus a
// MEM_TIMEOUT=3 instance sharing the same stimulus.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_issue;
    logic [15:0] ALU_OUT;
    logic        ALU_Z, ALU_N, ALU_C, ALU_V;
    logic [15:0] PC;
    logic [15:0] D_Imm;
    logic [3:0]  D_WriteReg;
    logic [1:0]  C_WBSrc;
    logic        C_RegWrite, C_FlagWrite, C_MemRead;
    logic        mem_valid;
    logic [15:0] D_MemData;

    logic        wb_ready, mem_req, rf_we, wb_done, wb_err;
    logic [3:0]  rf_waddr, flags;
    logic [15:0] rf_wdata, alu_reg;
    logic        wb_ready_t, mem_req_t, rf_we_t, wb_done_t, wb_err_t;
    logic [3:0]  rf_waddr_t, flags_t;
    logic [15:0] rf_wdata_t, alu_reg_t;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .wb_issue(wb_issue), .wb_ready(wb_ready),
        .ALU_OUT(ALU_OUT), .ALU_Z(ALU_Z), .ALU_N(ALU_N), .ALU_C(ALU_C), .ALU_V(ALU_V),
        .PC(PC), .D_Imm(D_Imm), .D_WriteReg(D_WriteReg), .C_WBSrc(C_WBSrc),
        .C_RegWrite(C_RegWrite), .C_FlagWrite(C_FlagWrite), .C_MemRead(C_MemRead),
        .mem_req(mem_req), .mem_valid(mem_valid), .D_MemData(D_MemData),
        .RF_WE(rf_we), .RF_WADDR(rf_waddr), .RF_WDATA(rf_wdata), .FLAGS(flags),
        .ALUOut_Reg(alu_reg), .wb_done(wb_done), .wb_err(wb_err)
    );

    alu_writeback_stage #(.MEM_TIMEOUT(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .wb_issue(wb_issue), .wb_ready(wb_ready_t),
        .ALU_OUT(ALU_OUT), .ALU_Z(ALU_Z), .ALU_N(ALU_N), .ALU_C(ALU_C), .ALU_V(ALU_V),
        .PC(PC), .D_Imm(D_Imm), .D_WriteReg(D_WriteReg), .C_WBSrc(C_WBSrc),
        .C_RegWrite(C_RegWrite), .C_FlagWrite(C_FlagWrite), .C_MemRead(C_MemRead),
        .mem_req(mem_req_t), .mem_valid(mem_valid), .D_MemData(D_MemData),
        .RF_WE(rf_we_t), .RF_WADDR(rf_waddr_t), .RF_WDATA(rf_wdata_t), .FLAGS(flags_t),
        .ALUOut_Reg(alu_reg_t), .wb_done(wb_done_t), .wb_err(wb_err_t)
    );

    task automatic clear_inputs;
        wb_issue = 1'b0; ALU_OUT = 16'h0000; {ALU_Z, ALU_N, ALU_C, ALU_V} = 4'b0000;
        PC = 16'h0000; D_Imm = 16'h0000; D_WriteReg = 4'd0; C_WBSrc = 2'b00;
        C_RegWrite = 1'b0; C_FlagWrite = 1'b0; C_MemRead = 1'b0;
        mem_valid = 1'b0; D_MemData = 16'h0000;
    endtask

    // Called at a negedge in the issue cycle; returns at the next negedge.
    task automatic issue(input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] imm,
                         input logic [3:0] wreg, input logic [1:0] src, input logic regw,
                         input logic flagw, input logic memrd, input logic [3:0] fl);
        ALU_OUT = alu; PC = pc; D_Imm = imm; D_WriteReg = wreg; C_WBSrc = src;
        C_RegWrite = regw; C_FlagWrite = flagw; C_MemRead = memrd;
        {ALU_Z, ALU_N, ALU_C, ALU_V} = fl;
        wb_issue = 1'b1;
        @(negedge clk);
        wb_issue = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        total++; if ({wb_ready, rf_we, wb_done, wb_err, mem_req} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 10000", {wb_ready, rf_we, wb_done, wb_err, mem_req}); end
        total++; if ({flags, alu_reg, rf_waddr, rf_wdata} !== 40'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {flags, alu_reg, rf_waddr, rf_wdata}); end
        total++; if ({wb_ready_t, rf_we_t, wb_done_t, wb_err_t, mem_req_t} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl_t: got %b want 10000", {wb_ready_t, rf_we_t, wb_done_t, wb_err_t, mem_req_t}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_write;
        total++; if (wb_ready !== 1'b1) begin
            bad++; $display("FAIL alu_ready_pre: got %b want 1", wb_ready); end
        issue(16'h1234, 16'h0010, 16'h0000, 4'd3, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, rf_waddr, rf_wdata, wb_done} !== {1'b1, 4'd3, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL alu_write: got %h want %h", {rf_we, rf_waddr, rf_wdata, wb_done}, {1'b1, 4'd3, 16'h1234, 1'b1}); end
        total++; if ({wb_ready, alu_reg} !== {1'b0, 16'h1234}) begin
            bad++; $display("FAIL alu_busy: got %h want %h", {wb_ready, alu_reg}, {1'b0, 16'h1234}); end
        @(negedge clk);
        total++; if ({rf_we, wb_done, wb_ready} !== 3'b001) begin
            bad++; $display("FAIL alu_after: got %b want 001", {rf_we, wb_done, wb_ready}); end
    endtask

    task automatic test_load;
        int err_seen;
        err_seen = 0;
        issue(16'h0040, 16'h0020, 16'h0000, 4'd5, 2'b01, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            total++; if ({mem_req, rf_we, wb_ready} !== 3'b100) begin
                bad++; $display("FAIL load_wait%0d: got %b want 100", c, {mem_req, rf_we, wb_ready}); end
            if (wb_err) err_seen++;
            if (c == 4) begin mem_valid = 1'b1; D_MemData = 16'hBEEF; end
            @(negedge clk);
        end
        mem_valid = 1'b0; D_MemData = 16'h0000;
        total++; if ({rf_we, rf_waddr, rf_wdata, wb_done, mem_req} !== {1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0}) begin
            bad++; $display("FAIL load_write: got %h want %h", {rf_we, rf_waddr, rf_wdata, wb_done, mem_req}, {1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0}); end
        if (wb_err) err_seen++;
        @(negedge clk);
        if (wb_err) err_seen++;
        total++; if (err_seen != 0) begin
            bad++; $display("FAIL load_no_err: got %0d err cycles want 0", err_seen); end
        total++; if ({rf_we, wb_done, wb_ready} !== 3'b001) begin
            bad++; $display("FAIL load_after: got %b want 001", {rf_we, wb_done, wb_ready}); end
    endtask

    task automatic test_timeout;
        int we_seen;
        we_seen = 0;
        issue(16'h0000, 16'h0000, 16'h0000, 4'd6, 2'b01, 1'b1, 1'b0, 1'b1, 4'b0000);
        for (int c = 1; c <= 3; c++) begin
            total++; if ({mem_req_t, wb_err_t, wb_ready_t} !== 3'b100) begin
                bad++; $display("FAIL tmo_wait%0d: got %b want 100", c, {mem_req_t, wb_err_t, wb_ready_t}); end
            if (rf_we_t) we_seen++;
            @(negedge clk);
        end
        total++; if ({wb_err_t, rf_we_t, wb_ready_t, mem_req_t, wb_done_t} !== 5'b10100) begin
            bad++; $display("FAIL tmo_err: got %b want 10100", {wb_err_t, rf_we_t, wb_ready_t, mem_req_t, wb_done_t}); end
        // Late data: completes the long-timeout instance, ignored by the aborted one
        mem_valid = 1'b1; D_MemData = 16'h7777;
        @(negedge clk);
        mem_valid = 1'b0; D_MemData = 16'h0000;
        total++; if ({wb_err_t, rf_we_t, wb_done_t, wb_ready_t} !== 4'b0001) begin
            bad++; $display("FAIL tmo_ignore_valid: got %b want 0001", {wb_err_t, rf_we_t, wb_done_t, wb_ready_t}); end
        total++; if ({rf_we, rf_waddr, rf_wdata, wb_err} !== {1'b1, 4'd6, 16'h7777, 1'b0}) begin
            bad++; $display("FAIL tmo_long_load: got %h want %h", {rf_we, rf_waddr, rf_wdata, wb_err}, {1'b1, 4'd6, 16'h7777, 1'b0}); end
        if (rf_we_t) we_seen++;
        @(negedge clk);
        total++; if ((we_seen != 0) || (rf_we_t !== 1'b0)) begin
            bad++; $display("FAIL tmo_no_write: got %0d we cycles want 0", we_seen); end
    endtask

    task automatic test_link_r0;
        issue(16'h5555, 16'hFFFF, 16'h0000, 4'd7, 2'b10, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, rf_waddr, rf_wdata, wb_done} !== {1'b1, 4'd7, 16'h0000, 1'b1}) begin
            bad++; $display("FAIL link_wrap: got %h want %h", {rf_we, rf_waddr, rf_wdata, wb_done}, {1'b1, 4'd7, 16'h0000, 1'b1}); end
        @(negedge clk);
        issue(16'h5555, 16'h1233, 16'h0000, 4'd0, 2'b10, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, wb_done, rf_wdata} !== {1'b0, 1'b1, 16'h1234}) begin
            bad++; $display("FAIL link_r0: got %h want %h", {rf_we, wb_done, rf_wdata}, {1'b0, 1'b1, 16'h1234}); end
        @(negedge clk);
    endtask

    task automatic test_imm_mem0;
        issue(16'h1111, 16'h0000, 16'hA5A5, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd2, 16'hA5A5}) begin
            bad++; $display("FAIL imm_write: got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd2, 16'hA5A5}); end
        @(negedge clk);
        issue(16'h2222, 16'h0000, 16'h3333, 4'd9, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd9, 16'h0000}) begin
            bad++; $display("FAIL mem_no_load: got %h want %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd9, 16'h0000}); end
        @(negedge clk);
        issue(16'h4444, 16'h0000, 16'h0000, 4'd9, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, wb_done} !== 2'b01) begin
            bad++; $display("FAIL no_regwrite: got %b want 01", {rf_we, wb_done}); end
        @(negedge clk);
    endtask

    task automatic test_flags;
        issue(16'h0000, 16'h0000, 16'h0000, 4'd1, 2'b00, 1'b1, 1'b1, 1'b0, 4'b1010);
        total++; if (flags !== 4'b1010) begin
            bad++; $display("FAIL flags_write: got %b want 1010", flags); end
        @(negedge clk);
        issue(16'h8000, 16'h0000, 16'h0000, 4'd1, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({flags, alu_reg} !== {4'b1010, 16'h8000}) begin
            bad++; $display("FAIL flags_hold: got %h want %h", {flags, alu_reg}, {4'b1010, 16'h8000}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load;
        issue(16'h0ABC, 16'h0000, 16'h0000, 4'd8, 2'b01, 1'b1, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin
            bad++; $display("FAIL rst_pre_req: got %b want 1", mem_req); end
        rst_n = 1'b0;
        #1;
        total++; if ({wb_ready, rf_we, wb_done, wb_err, mem_req, flags, alu_reg} !== {5'b10000, 4'b0000, 16'h0000}) begin
            bad++; $display("FAIL rst_mid: got %h want %h", {wb_ready, rf_we, wb_done, wb_err, mem_req, flags, alu_reg}, {5'b10000, 4'b0000, 16'h0000}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({rf_we, wb_ready, mem_req} !== 3'b010) begin
            bad++; $display("FAIL rst_release: got %b want 010", {rf_we, wb_ready, mem_req}); end
        issue(16'h00FF, 16'h0000, 16'h0000, 4'd4, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000);
        total++; if ({rf_we, rf_waddr, rf_wdata, wb_done} !== {1'b1, 4'd4, 16'h00FF, 1'b1}) begin
            bad++; $display("FAIL rst_reissue: got %h want %h", {rf_we, rf_waddr, rf_wdata, wb_done}, {1'b1, 4'd4, 16'h00FF, 1'b1}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load();
        test_timeout();
        test_link_r0();
        test_imm_mem0();
        test_flags();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
